mem_arbiter: RTL and testbench

Single-port memory arbiter that lets the core's instruction-fetch port and load/store port share one unified synchronous word memory, so the fetch and data paths no longer need separate memories. It grants one access per cycle, routes the one-cycle-late read data back to the requester that owns it, and raises a stall to the core while any request is waiting. Data accesses win by default; a burst limit keeps fetch from starving.

---
 rtl/mem_arb_pkg.sv | 13 +
 rtl/mem_arbiter.sv | 102 ++++++++++
 tb/tb_mem_arbiter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter: response owner encoding and
// the width of the data-burst streak counter.
package mem_arb_pkg;

    localparam int STREAK_W = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter sharing one synchronous word memory between the
// fetch port and the load/store port, with a data-burst limit against starvation.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int MAX_D_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [3:0]        d_mask,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_mask,
    input  logic [31:0]       mem_rdata,
    output logic              stall
);

    localparam logic [STREAK_W-1:0] MAX_STREAK = STREAK_W'(MAX_D_BURST);

    logic [STREAK_W-1:0] streak_q, streak_d;
    owner_e              owner_q, owner_d;

    // Data wins by default; fetch takes the slot once data has used up its burst.
    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!rst) begin
            if (d_req && !(i_req && (streak_q == MAX_STREAK))) begin
                d_gnt = 1'b1;
            end else if (i_req) begin
                i_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        mem_en    = i_gnt | d_gnt;
        mem_we    = d_gnt & d_we;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_mask  = '0;
        if (d_gnt) begin
            mem_addr = d_addr;
            if (d_we) begin
                mem_wdata = d_wdata;
                mem_mask  = d_mask;
            end
        end else if (i_gnt) begin
            mem_addr = i_addr;
        end
    end

    assign stall = ((i_req & ~i_gnt) | (d_req & ~d_gnt)) & ~rst;

    always_comb begin
        streak_d = streak_q;
        if (i_gnt || !i_req) begin
            streak_d = '0;
        end else if (d_gnt && (streak_q != MAX_STREAK)) begin
            streak_d = streak_q + 1'b1;
        end

        owner_d = OWN_NONE;
        if (i_gnt) begin
            owner_d = OWN_I;
        end else if (d_gnt && !d_we) begin
            owner_d = OWN_D;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q  <= OWN_NONE;
            streak_q <= '0;
        end else begin
            owner_q  <= owner_d;
            streak_q <= streak_d;
        end
    end

    // A read still in flight when reset rises is dropped, so the owner is masked by rst.
    assign i_rvalid = (owner_q == OWN_I) & ~rst;
    assign d_rvalid = (owner_q == OWN_D) & ~rst;
    assign i_rdata  = i_rvalid ? mem_rdata : 32'h0;
    assign d_rdata  = d_rvalid ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural word memory and a response
// scoreboard filled at grant time and drained when read data comes back.
module tb_mem_arbiter;

    typedef struct {
        logic        isI;
        logic [31:0] data;
    } resp_t;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [7:0]  i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [7:0]  d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_mask;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_mask;
    logic [31:0] mem_rdata;
    logic        stall;

    logic [31:0] memArr [0:255];
    logic [31:0] refMem [0:255];
    resp_t       respQ [$];
    int          checks;
    int          failures;

    mem_arbiter #(.ADDR_W(8), .MAX_D_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_mask(d_mask),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_mask(mem_mask), .mem_rdata(mem_rdata), .stall(stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory: byte-masked writes, registered reads.
    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_mask[b]) memArr[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end
        end else if (mem_en) begin
            mem_rdata <= memArr[mem_addr];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(
        input string       tag,
        input logic        r,
        input logic        ireq,
        input logic [7:0]  iaddr,
        input logic        dreq,
        input logic        dwe,
        input logic [7:0]  daddr,
        input logic [31:0] dwdata,
        input logic [3:0]  dmask,
        input logic        expI,
        input logic        expD
    );
        resp_t       e;
        logic [31:0] word;
        @(negedge clk);
        rst     = r;
        i_req   = ireq;
        i_addr  = iaddr;
        d_req   = dreq;
        d_we    = dwe;
        d_addr  = daddr;
        d_wdata = dwdata;
        d_mask  = dmask;
        #1;
        if (r) respQ.delete();
        if (respQ.size() > 0) begin
            e = respQ.pop_front();
            checkOutput({tag, ".i_rvalid"}, 32'(i_rvalid), 32'(e.isI));
            checkOutput({tag, ".d_rvalid"}, 32'(d_rvalid), 32'(!e.isI));
            checkOutput({tag, ".rdata"}, e.isI ? i_rdata : d_rdata, e.data);
        end else begin
            checkOutput({tag, ".i_rvalid"}, 32'(i_rvalid), 32'd0);
            checkOutput({tag, ".d_rvalid"}, 32'(d_rvalid), 32'd0);
            checkOutput({tag, ".rdata0"}, i_rdata | d_rdata, 32'h0);
        end
        checkOutput({tag, ".i_gnt"}, 32'(i_gnt), 32'(expI));
        checkOutput({tag, ".d_gnt"}, 32'(d_gnt), 32'(expD));
        checkOutput({tag, ".stall"}, 32'(stall), r ? 32'd0 : 32'((ireq & !expI) | (dreq & !expD)));
        checkOutput({tag, ".mem_en"}, 32'(mem_en), 32'(expI | expD));
        checkOutput({tag, ".mem_we"}, 32'(mem_we), 32'(expD & dwe));
        if (r || expI || expD) begin
            checkOutput({tag, ".mem_addr"}, 32'(mem_addr), r ? 32'd0 : (expD ? 32'(daddr) : 32'(iaddr)));
            checkOutput({tag, ".mem_wdata"}, mem_wdata, (expD && dwe) ? dwdata : 32'h0);
            checkOutput({tag, ".mem_mask"}, 32'(mem_mask), (expD && dwe) ? 32'(dmask) : 32'd0);
        end
        if (expI) begin
            respQ.push_back('{isI: 1'b1, data: refMem[iaddr]});
        end else if (expD && !dwe) begin
            respQ.push_back('{isI: 1'b0, data: refMem[daddr]});
        end else if (expD && dwe) begin
            word = refMem[daddr];
            for (int b = 0; b < 4; b++) begin
                if (dmask[b]) word[b*8 +: 8] = dwdata[b*8 +: 8];
            end
            refMem[daddr] = word;
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        mem_rdata = 32'h0;
        for (int a = 0; a < 256; a++) begin
            memArr[a] = {8'hA5, 8'(a), ~8'(a), 8'h3C};
            refMem[a] = {8'hA5, 8'(a), ~8'(a), 8'h3C};
        end
        memArr[4] = 32'h00500093;
        refMem[4] = 32'h00500093;
        rst = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; d_mask = '0;

        applyStimulus("rst0", 1, 1, 8'h08, 1, 0, 8'h20, 32'h0, 4'h0, 0, 0);
        applyStimulus("rst1", 1, 1, 8'h08, 1, 0, 8'h20, 32'h0, 4'h0, 0, 0);

        // Burst limit of 4: four data grants, then one fetch grant.
        for (int k = 0; k < 10; k++) begin
            applyStimulus("contend", 0, 1, 8'h08, 1, 0, 8'h20, 32'h0, 4'h0,
                          (k % 5) == 4, (k % 5) != 4);
        end

        applyStimulus("fetch", 0, 1, 8'h04, 0, 0, 8'h00, 32'h0, 4'h0, 1, 0);
        applyStimulus("store", 0, 0, 8'h00, 1, 1, 8'h10, 32'hDEADBEEF, 4'b0011, 0, 1);
        applyStimulus("load", 0, 0, 8'h00, 1, 0, 8'h10, 32'h0, 4'h0, 0, 1);
        applyStimulus("idle", 0, 0, 8'h00, 0, 0, 8'h00, 32'h0, 4'h0, 0, 0);

        applyStimulus("rdN", 0, 1, 8'h08, 0, 0, 8'h00, 32'h0, 4'h0, 1, 0);
        applyStimulus("rdN1", 1, 0, 8'h00, 0, 0, 8'h00, 32'h0, 4'h0, 0, 0);
        applyStimulus("rdN2", 0, 0, 8'h00, 0, 0, 8'h00, 32'h0, 4'h0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            applyStimulus("postrst", 0, 1, 8'h0C, 1, 0, 8'h24, 32'h0, 4'h0, k == 4, k != 4);
        end

        for (int k = 0; k < 6; k++) begin
            applyStimulus("alt", 0, k[0] == 1'b0, 8'(8'h40 + k), k[0] == 1'b1, 0, 8'(8'h60 + k),
                          32'h0, 4'h0, k[0] == 1'b0, k[0] == 1'b1);
        end

        applyStimulus("same0", 0, 1, 8'h30, 1, 1, 8'h30, 32'h12345678, 4'b1111, 0, 1);
        applyStimulus("same1", 0, 1, 8'h30, 0, 0, 8'h00, 32'h0, 4'h0, 1, 0);
        applyStimulus("drain", 0, 0, 8'h00, 0, 0, 8'h00, 32'h0, 4'h0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
